counter_capture: RTL
====================

COUNTER_CAPTURE -- requirements
Module: counter_capture

Interface
REQ-001 The block SHALL have parameter COUNTER_WIDTH, default 32: the width of the incoming count and of the stamp/delta outputs.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: the capture queue depth; legal values are powers of two >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset; synchronous, active-high.
REQ-005 The block SHALL have port cnt, input, COUNTER_WIDTH bits: the free-running count from the upstream counter.
REQ-006 The block SHALL have port trig, input, 1 bit: the event input; it is synchronous to clk.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the queue head is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the head.
REQ-009 The block SHALL have port out_stamp, output, COUNTER_WIDTH bits: the captured cnt value of the head entry.
REQ-010 The block SHALL have port out_delta, output, COUNTER_WIDTH bits: the head stamp minus the previous stored stamp, modulo 2^COUNTER_WIDTH.
REQ-011 The block SHALL have port out_first, output, 1 bit: the head is the first entry stored since reset.
REQ-012 The block SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: the number of entries held.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a capture is dropped.
REQ-014 The block SHALL have port ovf_clr, input, 1 bit: clears overflow.

Function
REQ-015 The block SHALL register trig into trig_q each cycle and detect an event in any cycle where trig=1 and trig_q=0.
REQ-016 In an event cycle, the block SHALL capture the cnt value present at that same clock edge as the stamp; there is no added pipeline skew.
REQ-017 The block SHALL push a capture iff an event occurs and either (level < FIFO_DEPTH) or a pop occurs in the same cycle.
REQ-018 A pop SHALL occur iff out_valid=1 and out_ready=1; the entry is removed on that edge.
REQ-019 Push latency SHALL be 1 cycle: an event in cycle N into an empty queue gives out_valid=1 in cycle N+1 with that entry at the head.
REQ-020 out_stamp, out_delta and out_first SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 The block SHALL compute delta as stamp minus prev_stamp, truncated to COUNTER_WIDTH bits, so that wrap-around yields the correct forward distance.
REQ-022 The first stored entry after reset SHALL have delta=0 and first=1; all later entries SHALL have first=0.
REQ-023 prev_stamp and the first-entry state SHALL update only on pushed captures; dropped captures SHALL NOT affect them.
REQ-024 An event with a full queue and no simultaneous pop SHALL be dropped and SHALL set overflow on the next edge.
REQ-025 ovf_clr=1 SHALL clear overflow on the next edge; if a drop occurs in the same cycle, the set SHALL win and overflow stays 1.
REQ-026 level SHALL increment on push-only, decrement on pop-only, and hold on push+pop or on neither.
REQ-027 level SHALL never exceed FIFO_DEPTH, and out_valid SHALL equal (level != 0).
REQ-028 The queue SHALL use wrap-around read and write pointers of clog2(FIFO_DEPTH) bits.

Reset
REQ-029 While rst=1, the block SHALL drive out_valid=0, level=0, overflow=0, out_stamp=0, out_delta=0 and out_first=0.
REQ-030 While rst=1, the block SHALL set the internal first-entry state to 1, prev_stamp to 0 and both pointers to 0.
REQ-031 Reset SHALL set trig_q=1, so that trig held high through reset release produces no event until trig has been seen low.
REQ-032 Reset mid-operation SHALL discard all queued entries on the reset edge, and events during rst=1 SHALL be ignored.

Verification
REQ-033 Single capture: trig pulses 0->1 while cnt=100 -> next cycle out_valid=1, stamp=100, delta=0, first=1, level=1.
REQ-034 Delta: captures at cnt=100 and cnt=137 with out_ready=1 -> second entry has stamp=137, delta=37, first=0.
REQ-035 Wrap: COUNTER_WIDTH=8, captures at cnt=250 then cnt=4 -> second entry has delta=10.
REQ-036 Overflow: out_ready=0 and 5 events with FIFO_DEPTH=4 -> level=4 and overflow=1; the 5th stamp is absent, and the delta of the entry after draining and re-capturing is relative to the 4th stamp.
REQ-037 Full with simultaneous pop: queue full, event and pop in the same cycle -> level stays 4, overflow stays 0, and the new entry appears last.
REQ-038 Clear/reset: ovf_clr=1 with no drop -> overflow=0 next cycle; rst with 3 entries queued -> level=0, out_valid=0, and the next capture has first=1.

Source files
------------

// File: rtl/counter_capture_if.sv
// counter_capture_if: head-of-queue valid/ready bundle.
// Carries out_valid/out_ready plus the head's stamp, delta and first flag.
interface counter_capture_if #(
  parameter int W = 32
) ();
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_stamp;
  logic [W-1:0] out_delta;
  logic         out_first;

  modport master (
    output out_valid,
    output out_stamp,
    output out_delta,
    output out_first,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_stamp,
    input  out_delta,
    input  out_first,
    output out_ready
  );
endinterface

// File: rtl/counter_capture.sv
// counter_capture: stamps rising edges of trig with cnt into a small queue.
// Ports: clk, rst (sync, active-high), cnt, trig, out (head bundle),
//        level (entries held), overflow (sticky drop flag), ovf_clr.
module counter_capture #(
  parameter int COUNTER_WIDTH = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COUNTER_WIDTH-1:0]      cnt,
  input  logic                          trig,
  counter_capture_if.master             out,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          ovf_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [COUNTER_WIDTH-1:0] stamp;
    logic [COUNTER_WIDTH-1:0] delta;
    logic                     first;
  } entry_t;

  entry_t                   mem [FIFO_DEPTH];
  entry_t                   head;
  entry_t                   wr_entry;
  logic [AW-1:0]            wptr;
  logic [AW-1:0]            rptr;
  logic                     trig_q;
  logic                     first_q;
  logic [COUNTER_WIDTH-1:0] prev_stamp;
  logic                     ev;
  logic                     pop;
  logic                     push;
  logic                     drop;
  logic                     valid;

  always_comb begin
    valid = (level != '0);
    ev    = trig & ~trig_q;
    pop   = valid & out.out_ready;
    // A full queue still accepts when the head leaves on the same edge.
    push  = ev & ((level != FULL) | pop);
    drop  = ev & ~push;
    wr_entry.stamp = cnt;
    wr_entry.delta = first_q ? '0 : cnt - prev_stamp;
    wr_entry.first = first_q;
    head  = mem[rptr];
  end

  // Empty queue presents zeros so reset and idle look identical.
  assign out.out_valid = valid;
  assign out.out_stamp = valid ? head.stamp : '0;
  assign out.out_delta = valid ? head.delta : '0;
  assign out.out_first = valid ? head.first : 1'b0;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // trig_q=1 so a trig held high across reset is not an event.
      trig_q     <= 1'b1;
      first_q    <= 1'b1;
      prev_stamp <= '0;
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      overflow   <= 1'b0;
    end else begin
      trig_q <= trig;
      if (push) begin
        wptr       <= wptr + AW'(1);
        prev_stamp <= cnt;
        first_q    <= 1'b0;
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end
endmodule
